sync_debounce_edge: RTL and testbench

//  Conditions a raw asynchronous 1-bit input d for use inside the clocked design.

---
 rtl/sync_debounce_edge.sv | 134 +++++++++++++
 tb/tb_sync_debounce_edge.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/sync_debounce_edge.sv
// Synchronizes a raw asynchronous level, debounces it with a 4-state FSM and
// produces a registered level (q/qb) plus single-cycle rise/fall strobes.
module sync_debounce_edge #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    input  logic en,
    output logic q,
    output logic qb,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync;
    logic                   s;
    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   q_nxt;
    logic                   rise_nxt;
    logic                   fall_nxt;
    logic                   busy_nxt;

    assign s = sync[SYNC_STAGES-1];

    // Synchronizer chain runs every cycle regardless of en.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync <= {SYNC_STAGES{1'b0}};
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
        end
    end

    // Next-state and output logic; en=0 freezes state, counter and level.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        q_nxt     = q;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        if (en) begin
            case (state)
                STABLE_LO: begin
                    if (s) begin
                        state_nxt = PEND_HI;
                        cnt_nxt   = CNT_W'(1);
                    end else begin
                        state_nxt = STABLE_LO;
                    end
                end
                PEND_HI: begin
                    if (!s) begin
                        state_nxt = STABLE_LO;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_MAX) begin
                        state_nxt = STABLE_HI;
                        q_nxt     = 1'b1;
                        rise_nxt  = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                STABLE_HI: begin
                    if (!s) begin
                        state_nxt = PEND_LO;
                        cnt_nxt   = CNT_W'(1);
                    end else begin
                        state_nxt = STABLE_HI;
                    end
                end
                PEND_LO: begin
                    if (s) begin
                        state_nxt = STABLE_HI;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_MAX) begin
                        state_nxt = STABLE_LO;
                        q_nxt     = 1'b0;
                        fall_nxt  = 1'b1;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                    q_nxt     = 1'b0;
                end
            endcase
        end else begin
            state_nxt = state;
        end
        busy_nxt = (state_nxt == PEND_HI) || (state_nxt == PEND_LO);
    end

    // State register and registered outputs; busy tracks the pending states.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= STABLE_LO;
            cnt   <= '0;
            q     <= 1'b0;
            qb    <= 1'b1;
            rise  <= 1'b0;
            fall  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            q     <= q_nxt;
            qb    <= ~q_nxt;
            rise  <= rise_nxt;
            fall  <= fall_nxt;
            busy  <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_sync_debounce_edge.sv
// Directed bench for sync_debounce_edge: a per-edge vector table plus
// hand-written sequences for edge-timing, enable-stall and mid-pend reset.
module tb_sync_debounce_edge;

    logic clk = 1'b0;
    logic rst, d, en;
    logic q, qb, rise, fall, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       d;
        logic       en;
        logic [4:0] exp;   // {q, qb, rise, fall, busy}
    } vec_t;

    vec_t vecs[$];

    sync_debounce_edge #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .en  (en),
        .q   (q),
        .qb  (qb),
        .rise(rise),
        .fall(fall),
        .busy(busy)
    );

    always #100 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive inputs, advance one edge, sample 1 unit later.
    task automatic step(input logic r, input logic dd, input logic e);
        rst = r;
        d   = dd;
        en  = e;
        @(posedge clk);
        #1;
        checks++;
        if (rise && fall) begin
            errors++;
            $display("FAIL rise_fall_excl: got rise=%0b fall=%0b expected not both", rise, fall);
        end
    endtask

    task automatic add(input logic r, input logic dd, input logic e, input logic [4:0] x);
        vec_t v;
        v.rst = r; v.d = dd; v.en = e; v.exp = x;
        vecs.push_back(v);
    endtask

    initial begin
        int edge_a, edge_b, rises, falls;
        rst = 1'b1; d = 1'b1; en = 1'b1;

        // reset with d=1, release, qualify high
        add(1, 1, 1, 5'b01000); add(1, 1, 1, 5'b01000);
        add(0, 1, 1, 5'b01000); add(0, 1, 1, 5'b01000);
        add(0, 1, 1, 5'b01001); add(0, 1, 1, 5'b01001); add(0, 1, 1, 5'b01001);
        add(0, 1, 1, 5'b10100); add(0, 1, 1, 5'b10000);
        // d=0 held 10 periods: fall at 6th edge
        add(0, 0, 1, 5'b10000); add(0, 0, 1, 5'b10000);
        add(0, 0, 1, 5'b10001); add(0, 0, 1, 5'b10001); add(0, 0, 1, 5'b10001);
        add(0, 0, 1, 5'b01010);
        for (int i = 0; i < 4; i++) add(0, 0, 1, 5'b01000);
        // 3-period pulse: rejected
        add(0, 1, 1, 5'b01000); add(0, 1, 1, 5'b01000); add(0, 1, 1, 5'b01001);
        add(0, 0, 1, 5'b01001); add(0, 0, 1, 5'b01001);
        add(0, 0, 1, 5'b01000); add(0, 0, 1, 5'b01000);
        // toggling every cycle: busy toggles, q never moves
        add(0, 1, 1, 5'b01000); add(0, 0, 1, 5'b01000);
        add(0, 1, 1, 5'b01001); add(0, 0, 1, 5'b01000);
        add(0, 1, 1, 5'b01001); add(0, 0, 1, 5'b01000);
        add(0, 0, 1, 5'b01001); add(0, 0, 1, 5'b01000); add(0, 0, 1, 5'b01000);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].d, vecs[i].en);
            chk($sformatf("vec%0d_q_qb_rise_fall_busy", i), int'({q, qb, rise, fall, busy}),
                int'(vecs[i].exp));
        end

        // d rises 1 unit before edge E: q rises at E+5
        @(negedge clk);
        #99 d = 1'b1;
        @(posedge clk);
        #1;
        edge_a = -1;
        for (int k = 1; k <= 10 && edge_a < 0; k++) begin
            step(0, 1, 1);
            if (q) edge_a = k;
        end
        chk("edge_before_latency", edge_a, 5);
        for (int i = 0; i < 10; i++) step(0, 0, 1);
        chk("edge_return_low", int'(q), 0);

        // d rises 1 unit after edge E: q rises at E+6
        @(posedge clk);
        #1 d = 1'b1;
        edge_b = -1;
        for (int k = 1; k <= 10 && edge_b < 0; k++) begin
            step(0, 1, 1);
            if (q) edge_b = k;
        end
        chk("edge_after_latency", edge_b, 6);
        chk("edge_diff", edge_b - edge_a, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 1);
        chk("edge_b_return_low", int'(q), 0);

        // en low for 3 cycles while PEND_HI with cnt=2
        rises = 0; edge_a = -1;
        for (int k = 1; k <= 12; k++) begin
            if (k >= 5 && k <= 7) step(0, 1, 0);
            else step(0, 1, 1);
            if (rise) rises++;
            if (q && edge_a < 0) edge_a = k;
            if (k == 4 || k == 6) chk($sformatf("en_busy_e%0d", k), int'(busy), 1);
        end
        chk("en_stall_q_edge", edge_a, 9);
        chk("en_stall_rise_count", rises, 1);
        for (int i = 0; i < 10; i++) step(0, 0, 1);
        chk("en_return_low", int'(q), 0);

        // reset for one edge while PEND_HI with cnt=2
        for (int k = 1; k <= 4; k++) step(0, 1, 1);
        chk("pend_busy_before_rst", int'(busy), 1);
        step(1, 1, 1);
        chk("rst_mid_pend_outputs", int'({q, qb, rise, fall, busy}), int'(5'b01000));
        rises = 0; falls = 0; edge_a = -1;
        for (int k = 1; k <= 10; k++) begin
            step(0, 1, 1);
            if (rise) rises++;
            if (fall) falls++;
            if (q && edge_a < 0) edge_a = k;
            if (k == 2) chk("rst_restart_busy_e2", int'(busy), 0);
        end
        chk("rst_restart_q_edge", edge_a, 6);
        chk("rst_restart_rise_count", rises, 1);
        chk("rst_restart_fall_count", falls, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
